adc4_frame_asm: RTL

ADC4_FRAME_ASM -- requirements
Module: adc4_frame_asm

---
 rtl/adc4_frame_asm_pkg.sv | 23 ++
 rtl/adc4_frame_asm_if.sv | 16 +
 rtl/adc4_lock_fsm.sv | 63 ++++++
 rtl/adc4_frame_asm.sv | 128 ++++++++++++
 4 files changed

// File: rtl/adc4_frame_asm_pkg.sv
// Shared constants for the 4-channel ADC frame assembler: frame word, lock FSM
// encoding, test-pattern words and status counter width.
package adc4_frame_asm_pkg;

  localparam int CNT_W  = 16;
  localparam int N_CH   = 4;
  localparam int CH_W   = 12;
  localparam int LANE_W = 6;
  localparam int WORD_W = N_CH * CH_W;

  localparam logic [LANE_W-1:0] FRAME_PAT = 6'b111000;

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam logic [CH_W-1:0] PAT_A = 12'hAAA;
  localparam logic [CH_W-1:0] PAT_B = 12'h555;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/adc4_frame_asm_if.sv
// Receiver-side data bus of the frame assembler: lane word, frame/bit-slip
// status in, assembled samples and lock status out.
interface adc4_frame_asm_if;
  import adc4_frame_asm_pkg::*;

  logic [WORD_W-1:0] DIN;
  logic              FRAME_OK;
  logic              BS_IN;
  logic [WORD_W-1:0] DOUT;
  logic              DVALID;
  logic              LOCKED;

  modport master (output DIN, FRAME_OK, BS_IN, input DOUT, DVALID, LOCKED);
  modport slave  (input DIN, FRAME_OK, BS_IN, output DOUT, DVALID, LOCKED);

endinterface

// File: rtl/adc4_lock_fsm.sv
// HUNT/LOCK frame-alignment tracker fed by the registered frame status;
// also keeps the saturating count of lock losses.
module adc4_lock_fsm
  import adc4_frame_asm_pkg::*;
#(
  parameter int LOCK_CNT = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             frame_ok,
  input  logic             bs,
  input  logic             cnt_reset,
  output logic             locked,
  output logic             stay_locked,
  output logic [CNT_W-1:0] lost_cnt
);

  localparam logic [7:0] RUN_LAST = 8'(LOCK_CNT - 1);

  logic [0:0]       state_q;
  logic [7:0]       run_q;
  logic [CNT_W-1:0] lost_q;
  logic             good;
  logic             loss;

  // A bit-slip together with a bad frame is still a single bad cycle.
  assign good        = frame_ok & ~bs;
  assign loss        = (state_q == ST_LOCK) & ~good;
  assign stay_locked = (state_q == ST_LOCK) & good;
  assign locked      = (state_q == ST_LOCK);
  assign lost_cnt    = lost_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_HUNT;
      run_q   <= '0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (!good) begin
            run_q <= '0;
          end else if (run_q == RUN_LAST) begin
            state_q <= ST_LOCK;
            run_q   <= '0;
          end else begin
            run_q <= run_q + 1'b1;
          end
        end
        ST_LOCK: if (!good) state_q <= ST_HUNT;
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         lost_q <= '0;
    else if (cnt_reset) lost_q <= '0;
    else if (loss)      lost_q <= sat_inc(lost_q);
  end

endmodule

// File: rtl/adc4_frame_asm.sv
// 4-channel ADC frame assembler: two-stage lane-to-channel pipeline gated by
// frame lock. Optional test-pattern checker built when ADC4ASM_PATCHK_EN is defined.
module adc4_frame_asm
  import adc4_frame_asm_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int TWOS_COMP = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  adc4_frame_asm_if.slave  bus,
  output logic [CNT_W-1:0] lost_cnt,
  input  logic             cnt_reset,
  input  logic             PAT_ENB,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic TC_FLIP = (TWOS_COMP != 0);

  logic [WORD_W-1:0] s1_din;
  logic              s1_fok;
  logic              s1_bs;
  logic              s1_lock;
  logic              locked;
  logic              stay_locked;
  logic [WORD_W-1:0] mapped;
  logic [WORD_W-1:0] dout_q;
  logic              dvalid_q;
  logic              dvalid_d;

  adc4_lock_fsm #(.LOCK_CNT(LOCK_CNT)) u_lock (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .frame_ok   (s1_fok),
    .bs         (s1_bs),
    .cnt_reset  (cnt_reset),
    .locked     (locked),
    .stay_locked(stay_locked),
    .lost_cnt   (lost_cnt)
  );

  // A sample is tagged locked only if the FSM keeps lock on the edge that captures it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_din  <= '0;
      s1_fok  <= 1'b0;
      s1_bs   <= 1'b0;
      s1_lock <= 1'b0;
    end else begin
      s1_din  <= bus.DIN;
      s1_fok  <= bus.FRAME_OK;
      s1_bs   <= bus.BS_IN;
      s1_lock <= stay_locked;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mapped = '0;
    for (int c = 0; c < N_CH; c++) begin
      mapped[c*CH_W +: CH_W] = {s1_din[(2*c+1)*LANE_W +: LANE_W],
                                s1_din[(2*c)*LANE_W +: LANE_W]};
      mapped[c*CH_W + CH_W - 1] = mapped[c*CH_W + CH_W - 1] ^ TC_FLIP;
    end
  end

  assign dvalid_d = s1_lock & s1_fok;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      dvalid_q <= dvalid_d;
      if (dvalid_d) dout_q <= mapped;
    end
  end

  assign bus.DOUT   = dout_q;
  assign bus.DVALID = dvalid_q;
  assign bus.LOCKED = locked;

`ifdef ADC4ASM_PATCHK_EN
  logic             armed_q;
  logic             exp_a_q;
  logic [CNT_W-1:0] err_q;
  logic             chk;
  logic             exp_a;
  logic             mism;
  logic [CH_W-1:0]  exp_pat;

  // Phase comes from ch0 on the first checked sample, then alternates.
  always_comb begin
    chk     = PAT_ENB & dvalid_q;
    exp_a   = armed_q ? exp_a_q : (dout_q[CH_W-1:0] == PAT_A);
    exp_pat = exp_a ? PAT_A : PAT_B;
    mism    = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (dout_q[c*CH_W +: CH_W] != exp_pat) mism = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      armed_q <= 1'b0;
      exp_a_q <= 1'b0;
    end else if (!PAT_ENB) begin
      armed_q <= 1'b0;
    end else if (chk) begin
      armed_q <= 1'b1;
      exp_a_q <= ~exp_a;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)           err_q <= '0;
    else if (cnt_reset)   err_q <= '0;
    else if (chk && mism) err_q <= sat_inc(err_q);
  end

  assign err_cnt = err_q;
`else
  logic pat_enb_unused;
  assign pat_enb_unused = PAT_ENB;
  assign err_cnt        = '0;
`endif

endmodule
